mnist_frame_streamer: RTL and testbench

Host-side feeder for the CNN inference core. Collects one 28×28 u8 image from a byte-wide host interface with backpressure into a local 784-entry buffer. Replays the buffer to the core as a single gap-free burst of `data_valid` cycles, then waits for the core's `out_valid`/`decision`. Returns the class, or a timeout code, to the host as a one-cycle result pulse.

---
 rtl/mnist_frame_streamer.sv | 199 +++++++++++++++++++
 tb/tb_mnist_frame_streamer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mnist_frame_streamer.sv
// mnist_frame_streamer: buffers one 28x28 u8 frame from the host,
// replays it to the CNN core as one burst and returns the decision.
module mnist_frame_streamer #(
  parameter int PIXELS   = 784,
  parameter int ADDR_W   = 10,
  parameter int WAIT_MAX = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_host_byte,
  input  logic       i_host_valid,
  output logic       o_host_ready,
  input  logic       i_host_abort,
  output logic [7:0] o_data_in,
  output logic       o_data_valid,
  input  logic [3:0] i_cnn_decision,
  input  logic       i_cnn_out_valid,
  output logic [3:0] o_result,
  output logic       o_result_valid,
  output logic       o_timeout,
  output logic       o_busy
);

  // One spare bit so the read counter can sit at PIXELS after the
  // final address even when PIXELS == 2**ADDR_W.
  localparam int CNT_W  = ADDR_W + 1;
  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(PIXELS - 1);
  localparam logic [CNT_W-1:0]  PIX_END   = CNT_W'(PIXELS);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
  localparam logic [3:0]        TMO_CODE  = 4'hF;

  typedef enum logic [1:0] {
    S_LOAD,
    S_STREAM,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]        r_mem [DEPTH];
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_host_ready;
  logic [7:0]        r_data_in;
  logic              r_data_valid;
  logic [3:0]        r_result;
  logic              r_result_valid;
  logic              r_timeout;

  logic w_accept;
  logic w_wr_en;
  logic w_last_byte;
  logic w_rd_en;
  logic w_stream_done;
  logic w_core_hit;
  logic w_expire;

  // Handshake and event decode; an abort discards a coincident byte.
  assign w_accept      = (r_state == S_LOAD) && i_host_valid
                         && r_host_ready;
  assign w_wr_en       = w_accept && !i_host_abort;
  assign w_last_byte   = w_wr_en && (r_wr_cnt == LAST_PIX);
  assign w_rd_en       = (r_state == S_STREAM) && (r_rd_cnt < PIX_END);
  assign w_stream_done = (r_state == S_STREAM) && (r_rd_cnt == PIX_END);
  assign w_core_hit    = (r_state == S_WAIT) && i_cnn_out_valid;
  assign w_expire      = (r_state == S_WAIT) && !i_cnn_out_valid
                         && (r_wait_cnt == WAIT_LAST);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: load, burst, then wait for the core or timeout.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LOAD: begin
        if (w_last_byte) begin
          w_next = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_stream_done) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_core_hit || w_expire) begin
          w_next = S_LOAD;
        end
      end
      default: begin
        w_next = S_LOAD;
      end
    endcase
  end

  // Frame buffer write port; contents survive reset and abort.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_cnt[ADDR_W-1:0]] <= i_host_byte;
    end
  end

  // Synchronous read; the read register is the core-facing output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data_in    <= 8'd0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_rd_en;
      if (w_rd_en) begin
        r_data_in <= r_mem[r_rd_cnt[ADDR_W-1:0]];
      end
    end
  end

  // Host write counter; abort or frame completion rewinds it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_cnt <= '0;
    end else if (r_state == S_LOAD) begin
      if (i_host_abort || w_last_byte) begin
        r_wr_cnt <= '0;
      end else if (w_wr_en) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
    end
  end

  // Burst read address: one per cycle, parked at PIXELS for one
  // cycle while the final pixel is presented.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_cnt <= '0;
    end else if (w_rd_en) begin
      r_rd_cnt <= r_rd_cnt + 1'b1;
    end else if (w_stream_done) begin
      r_rd_cnt <= '0;
    end
  end

  // Cycles spent waiting for the core, zero in the first WAIT cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
    end else if (w_stream_done || w_core_hit || w_expire) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Result capture; a core strobe on the expiry cycle beats timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_result       <= 4'd0;
      r_result_valid <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_result_valid <= w_core_hit || w_expire;
      if (w_core_hit) begin
        r_result <= i_cnn_decision;
      end else if (w_expire) begin
        r_result  <= TMO_CODE;
        r_timeout <= 1'b1;
      end
    end
  end

  // Ready is registered from the next state so it is clean at the
  // host boundary and drops the cycle after the final byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_host_ready <= 1'b0;
    end else begin
      r_host_ready <= (w_next == S_LOAD);
    end
  end

  assign o_host_ready   = r_host_ready;
  assign o_data_in      = r_data_in;
  assign o_data_valid   = r_data_valid;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_timeout      = r_timeout;
  assign o_busy         = (r_state != S_LOAD);

endmodule

// File: tb/tb_mnist_frame_streamer.sv
// tb_mnist_frame_streamer: randomized frames against a queue-based
// reference; a negedge monitor scores the burst and result pulses.
module tb_mnist_frame_streamer;

  localparam int PIXELS   = 784;
  localparam int ADDR_W   = 10;
  localparam int WAIT_MAX = 64;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_host_byte;
  logic       i_host_valid;
  logic       o_host_ready;
  logic       i_host_abort;
  logic [7:0] o_data_in;
  logic       o_data_valid;
  logic [3:0] i_cnn_decision;
  logic       i_cnn_out_valid;
  logic [3:0] o_result;
  logic       o_result_valid;
  logic       o_timeout;
  logic       o_busy;

  mnist_frame_streamer #(
    .PIXELS   (PIXELS),
    .ADDR_W   (ADDR_W),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_host_byte     (i_host_byte),
    .i_host_valid    (i_host_valid),
    .o_host_ready    (o_host_ready),
    .i_host_abort    (i_host_abort),
    .o_data_in       (o_data_in),
    .o_data_valid    (o_data_valid),
    .i_cnn_decision  (i_cnn_decision),
    .i_cnn_out_valid (i_cnn_out_valid),
    .o_result        (o_result),
    .o_result_valid  (o_result_valid),
    .o_timeout       (o_timeout),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge n, cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    int         c;
  } pix_t;

  typedef struct {
    logic [3:0] r;
    logic       t;
    int         c;
  } res_t;

  pix_t exp_pix[$];
  res_t exp_res[$];
  int   n_chk   = 0;
  int   n_fail  = 0;
  bit   exp_tmo = 1'b0;
  int   last_e  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_host_ready"}, 32'(o_host_ready), 32'd0);
    check({tag, "_data_in"}, 32'(o_data_in), 32'd0);
    check({tag, "_data_valid"}, 32'(o_data_valid), 32'd0);
    check({tag, "_result"}, 32'(o_result), 32'd0);
    check({tag, "_result_valid"}, 32'(o_result_valid), 32'd0);
    check({tag, "_timeout"}, 32'(o_timeout), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  // Monitor: every burst beat and every result pulse must match the
  // head of its queue in both value and cycle.
  always @(negedge clk) begin : mon
    pix_t p;
    res_t r;
    if (o_data_valid) begin
      if (exp_pix.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL burst_extra @cyc %0d: data_valid=1 expected 0",
                 cyc);
      end else begin
        p = exp_pix.pop_front();
        check("pix_data", 32'(o_data_in), 32'(p.d));
        check("pix_cycle", 32'(cyc), 32'(p.c));
      end
    end
    if (o_result_valid) begin
      if (exp_res.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL result_extra @cyc %0d: result_valid=1 expected 0",
                 cyc);
      end else begin
        r = exp_res.pop_front();
        check("result", 32'(o_result), 32'(r.r));
        check("timeout", 32'(o_timeout), 32'(r.t));
        check("result_cycle", 32'(cyc), 32'(r.c));
      end
    end
  end

  // Host side: push bytes at pct% duty; optionally abort on an
  // accepted byte once abort_at bytes are in, then reload.
  task automatic load_frame(input bit pattern, input int pct,
                            input int abort_at, input bit spur);
    logic [7:0] fq[$];
    logic [7:0] b;
    bit         v;
    bit         ab;
    bit         aborted;
    int         guard;
    aborted = (abort_at < 0);
    guard   = 0;
    while (fq.size() < PIXELS) begin
      tick();
      guard++;
      if (guard > 40000) begin
        n_chk++;
        n_fail++;
        $display("FAIL load_timeout: %0d bytes accepted, need %0d",
                 fq.size(), PIXELS);
        finish_sim();
      end
      v  = (int'($urandom_range(99)) < pct);
      b  = pattern ? 8'(fq.size()) : 8'($urandom);
      ab = 1'b0;
      if (v && o_host_ready) begin
        if (!aborted && fq.size() >= abort_at) begin
          ab      = 1'b1;
          aborted = 1'b1;
          fq.delete();
        end else begin
          fq.push_back(b);
        end
      end
      i_host_valid    = v;
      i_host_byte     = b;
      i_host_abort    = ab;
      i_cnn_out_valid = spur && ($urandom_range(15) == 0);
      i_cnn_decision  = 4'($urandom_range(9));
    end
    last_e = cyc + 1;
    foreach (fq[k]) begin
      pix_t e;
      e.d = fq[k];
      e.c = last_e + 1 + k;
      exp_pix.push_back(e);
    end
  endtask

  // Core side: burst beats appear one cycle after each read address,
  // WAIT starts PIXELS+1 cycles after the last byte, and the result
  // pulses the cycle after the strobe or WAIT_MAX cycles into WAIT.
  task automatic run_core(input bit respond, input int d,
                          input logic [3:0] dec, input bit bp,
                          input int spur_px, input int rst_px);
    int   tw;
    int   tr;
    int   tp;
    int   ts;
    int   tx;
    res_t e;
    tw = last_e + PIXELS + 1;
    tr = respond ? tw + d : -1;
    tp = respond ? tw + d + 1 : tw + WAIT_MAX;
    ts = (spur_px >= 0) ? last_e + 1 + spur_px : -1;
    tx = (rst_px >= 0) ? last_e + 1 + rst_px : -1;
    if (rst_px < 0) begin
      if (!respond) exp_tmo = 1'b1;
      e.r = respond ? dec : 4'hF;
      e.t = exp_tmo;
      e.c = tp;
      exp_res.push_back(e);
    end
    forever begin
      tick();
      i_host_abort = 1'b0;
      i_host_byte  = 8'($urandom);
      if (cyc == tp) begin
        check("ready_on_pulse", 32'(o_host_ready), 32'd1);
        check("busy_on_pulse", 32'(o_busy), 32'd0);
        i_host_valid    = 1'b0;
        i_cnn_out_valid = 1'b0;
        break;
      end
      if (cyc == tx) begin
        i_rst = 1'b1;
        exp_pix.delete();
        tick();
        check_reset("mid_rst");
        i_rst           = 1'b0;
        i_host_valid    = 1'b0;
        i_cnn_out_valid = 1'b0;
        exp_tmo         = 1'b0;
        tick();
        check("ready_after_mid_rst", 32'(o_host_ready), 32'd1);
        break;
      end
      if (bp) check("bp_ready", 32'(o_host_ready), 32'd0);
      check("busy", 32'(o_busy), 32'd1);
      i_host_valid    = bp;
      i_cnn_out_valid = (cyc == tr) || (cyc == ts);
      i_cnn_decision  = (cyc == tr) ? dec : 4'($urandom_range(9));
    end
    check("pix_drained", 32'(exp_pix.size()), 32'd0);
    check("res_drained", 32'(exp_res.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst           = 1'b1;
    i_host_byte     = 8'd0;
    i_host_valid    = 1'b0;
    i_host_abort    = 1'b0;
    i_cnn_decision  = 4'd0;
    i_cnn_out_valid = 1'b0;
    tick();
    tick();
    check_reset("reset");
    i_rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(o_host_ready), 32'd1);

    // Basic frame, index pattern, core answers 7 after 50 cycles.
    load_frame(1'b1, 100, -1, 1'b0);
    run_core(1'b1, 50, 4'd7, 1'b0, -1, -1);

    // Throttled host with abort, spurious strobes, backpressure.
    load_frame(1'b0, 30, 300, 1'b1);
    run_core(1'b1, int'($urandom_range(WAIT_MAX - 2)),
             4'($urandom_range(9)), 1'b1, 400, -1);

    // Core never answers: timeout code, sticky flag.
    load_frame(1'b0, 100, -1, 1'b0);
    run_core(1'b0, 0, 4'd0, 1'b1, -1, -1);
    load_frame(1'b0, 70, -1, 1'b0);
    run_core(1'b1, 10, 4'd3, 1'b0, -1, -1);

    // Strobe on the expiry cycle wins, flag already set.
    load_frame(1'b0, 100, -1, 1'b1);
    run_core(1'b1, WAIT_MAX - 1, 4'd2, 1'b0, -1, -1);

    // Reset at burst pixel 400, then a clean frame.
    load_frame(1'b0, 100, -1, 1'b0);
    run_core(1'b1, 20, 4'd5, 1'b1, -1, 400);
    load_frame(1'b1, 100, -1, 1'b0);
    run_core(1'b1, 5, 4'd9, 1'b0, -1, -1);

    // Strobe on the expiry cycle with the flag clear.
    load_frame(1'b0, 100, -1, 1'b0);
    run_core(1'b1, WAIT_MAX - 1, 4'd2, 1'b1, -1, -1);

    // A few random frames.
    for (int f = 0; f < 3; f++) begin
      load_frame(1'b0, 40 + int'($urandom_range(60)), -1, 1'b1);
      run_core(1'b1, int'($urandom_range(WAIT_MAX - 1)),
               4'($urandom_range(9)), 1'($urandom_range(1)), -1, -1);
    end

    tick();
    tick();
    check("final_res_empty", 32'(exp_res.size()), 32'd0);
    finish_sim();
  end

endmodule
